decode_stage: RTL and testbench
===============================

# decode_stage

RV32I decode/issue stage placed directly upstream of the ALU32 execute block. It accepts one 32-bit instruction per handshake, reads operands from an internal 32x32 register file, and tracks in-flight destinations with a scoreboard so it can stall on RAW hazards. It then presents registered in0/in1/op/rd to ALU32 through a valid/ready output register. Results return through a writeback port that updates the register file and clears scoreboard bits.

## Interface
- No parameters; widths are fixed by ALU32 (32-bit operands, 4-bit opcode).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- inst_valid  in  1  upstream has an instruction.
- inst_ready  out  1  stage accepts `inst` this cycle.
- inst  in  32  RV32I instruction word.
- wb_en  in  1  writeback strobe.
- wb_rd  in  5  writeback destination.
- wb_data  in  32  writeback value.
- ex_valid  out  1  ALU operands valid.
- ex_ready  in  1  ALU consumes operands this cycle.
- ex_in0  out  32  ALU in0.
- ex_in1  out  32  ALU in1.
- ex_op  out  4  ALU opcode.
- ex_rd  out  5  destination register; 0 means no write.
- illegal  out  1  one-cycle pulse when an unsupported instruction is accepted.

## Operation
- ALU opcode map: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 SRA, 0101 NOR, 0110 SRL, 0111 SLL, 1000 U-type.
- Supported instructions:
  - ADD, SUB, AND, OR (R-type): in0=rs1, in1=rs2.
  - ADDI, ANDI, ORI: in0=rs1, in1=sign-extended imm[11:0].
  - SLLI, SRLI, SRAI with shamt==1 only: in0=rs1, in1=0.
  - LUI: op 1000, in0={12'b0, inst[31:12]}, in1=0.
- All other encodings, including shifts with shamt!=1:
  - accepted and dropped, with no ex_valid and no scoreboard change;
  - `illegal` pulses high for the cycle after acceptance.
- Register file:
  - 32 entries; x0 reads 0 and ignores writes;
  - writes occur on clk when wb_en;
  - reads are write-first: if wb_en and wb_rd equals a source register in the same cycle, the read returns wb_data.
- Scoreboard, busy[31:1]:
  - An accepted legal instruction with rd!=0 sets busy[rd].
  - wb_en with wb_rd!=0 clears busy[wb_rd].
  - If a set and a clear hit the same index in one cycle, set wins.
- Hazard: the instruction's sources are busy and not being written back this cycle. The sources are rs1 for all non-LUI formats, plus rs2 for R-type.
- WAW: a destination that is already busy also stalls.
- inst_ready = !hazard && (!ex_valid || ex_ready).
  - inst_ready may depend on `inst`.
  - inst_valid must not depend on inst_ready.
- Output register:
  - On accept of a legal instruction, ex_* load and ex_valid is set.
  - Otherwise, on ex_ready, ex_valid clears.
  - ex_* hold stable while ex_valid && !ex_ready.

## Timing
- Reset (sync):
  - ex_valid=0, illegal=0, busy=0, all registers=0;
  - ex_in0/ex_in1/ex_rd=0, ex_op=0000;
  - inst_ready is 1 in the first cycle after reset deassertion.
- Latency: acceptance in cycle N gives ex_valid in cycle N+1. Throughput is 1 instruction per cycle when there are no hazards and ex_ready=1.
- A writeback in cycle N clears a hazard combinationally in cycle N (write-first bypass), so the dependent instruction is accepted in cycle N.
- rst asserted mid-stall or while ex_valid: all state is cleared at the next edge and the pending output is discarded.
- The wb port is always accepted; there is no backpressure on writeback.

## Test plan
- Reset, then issue ADDI x1,x0,5 with ex_ready=1:
  - next cycle ex_valid=1, ex_op=0010, ex_in0=0, ex_in1=5, ex_rd=1;
  - busy[1]=1.
- ADDI x1,x0,-1 then ADD x2,x1,x1:
  - ADD stalls (inst_ready=0) until wb_en, wb_rd=1, wb_data=0xFFFFFFFF;
  - in that same cycle ADD is accepted;
  - next cycle ex_in0=ex_in1=0xFFFFFFFF, ex_op=0010.
- LUI x3,0xABCDE: ex_op=1000, ex_in0=0x000ABCDE, ex_in1=0.
- Hold ex_ready=0 for 3 cycles after issuing SUB x4,x5,x6:
  - ex_* stay stable and inst_ready=0;
  - on ex_ready=1 the next instruction is accepted the same cycle.
- SLLI x7,x1,2 and a MUL encoding:
  - each gives an `illegal` pulse the following cycle;
  - no ex_valid; busy[7] stays 0.
- Assert rst while ex_valid=1 and busy[1]=1: the next cycle shows ex_valid=0, busy=0, and x1 reads 0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode/issue stage feeding the ALU32 execute block.
//
// Decodes one instruction per inst_valid/inst_ready handshake, reads its
// operands from a 32x32 register file (write-first against the writeback
// port), and hands {ex_op, ex_in0, ex_in1, ex_rd} to the ALU through a
// registered ex_valid/ex_ready slot. A busy bit per register tracks
// in-flight destinations so RAW and WAW hazards stall issue.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid && ready are both high. A producer never waits on ready
// before raising valid, and holds its payload stable until the transfer.
// inst_ready is combinational and may depend on inst.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   inst_valid/inst_ready     instruction handshake, inst = RV32I word
//   wb_en, wb_rd, wb_data     writeback; always accepted, no backpressure
//   ex_valid/ex_ready         ALU operand handshake
//   ex_in0, ex_in1, ex_op     ALU operands and 4-bit opcode
//   ex_rd                     destination register (0 = no write)
//   illegal                   one-cycle pulse after an unsupported inst is accepted
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] inst,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [31:0] ex_in0,
    output logic [31:0] ex_in1,
    output logic [3:0]  ex_op,
    output logic [4:0]  ex_rd,
    output logic        illegal
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_SRA = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_LUI = 4'b1000;

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [31:0] regs [32];
    // Bit 0 is never set, so x0 can never cause a stall.
    logic [31:0] busy;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm_i;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};

    // Write-first reads: a same-cycle writeback to the source wins.
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 :
                     (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 :
                     (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];

    // A register is pending if busy and not being retired this very cycle.
    logic rs1_pend;
    logic rs2_pend;
    logic rd_pend;
    assign rs1_pend = busy[rs1] && !(wb_en && wb_rd == rs1);
    assign rs2_pend = busy[rs2] && !(wb_en && wb_rd == rs2);
    assign rd_pend  = busy[rd]  && !(wb_en && wb_rd == rd);

    logic        legal;
    logic        use_rs1;
    logic        use_rs2;
    logic [3:0]  dec_op;
    logic [31:0] dec_in0;
    logic [31:0] dec_in1;

    always_comb begin
        legal   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        dec_op  = OP_AND;
        dec_in0 = rs1_val;
        dec_in1 = 32'd0;
        case (opcode)
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec_in1 = rs2_val;
                if (funct7 == F7_BASE && funct3 == 3'b000) begin
                    legal = 1'b1;
                    dec_op = OP_ADD;
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    legal = 1'b1;
                    dec_op = OP_SUB;
                end else if (funct7 == F7_BASE && funct3 == 3'b111) begin
                    legal = 1'b1;
                    dec_op = OP_AND;
                end else if (funct7 == F7_BASE && funct3 == 3'b110) begin
                    legal = 1'b1;
                    dec_op = OP_OR;
                end
            end
            OPC_IMM: begin
                use_rs1 = 1'b1;
                case (funct3)
                    3'b000: begin legal = 1'b1; dec_op = OP_ADD; dec_in1 = imm_i; end
                    3'b111: begin legal = 1'b1; dec_op = OP_AND; dec_in1 = imm_i; end
                    3'b110: begin legal = 1'b1; dec_op = OP_OR;  dec_in1 = imm_i; end
                    // Only single-bit shifts exist in ALU32; in1 stays 0.
                    3'b001: begin
                        if (funct7 == F7_BASE && rs2 == 5'd1) begin
                            legal = 1'b1;
                            dec_op = OP_SLL;
                        end
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE && rs2 == 5'd1) begin
                            legal = 1'b1;
                            dec_op = OP_SRL;
                        end else if (funct7 == F7_ALT && rs2 == 5'd1) begin
                            legal = 1'b1;
                            dec_op = OP_SRA;
                        end
                    end
                    default: ;
                endcase
            end
            OPC_LUI: begin
                legal   = 1'b1;
                dec_op  = OP_LUI;
                dec_in0 = {12'd0, inst[31:12]};
            end
            default: ;
        endcase
    end

    // Illegal encodings have no operands, so they never stall on hazards.
    logic hazard;
    logic accept;
    assign hazard = legal && ((use_rs1 && rs1_pend) ||
                              (use_rs2 && rs2_pend) || rd_pend);
    assign inst_ready = !hazard && (!ex_valid || ex_ready);
    assign accept     = inst_valid && inst_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
            busy     <= 32'd0;
            ex_valid <= 1'b0;
            ex_in0   <= 32'd0;
            ex_in1   <= 32'd0;
            ex_op    <= OP_AND;
            ex_rd    <= 5'd0;
            illegal  <= 1'b0;
        end else begin
            if (wb_en && wb_rd != 5'd0) begin
                regs[wb_rd] <= wb_data;
                busy[wb_rd] <= 1'b0;
            end
            // Later assignment: a same-index set overrides the clear above.
            if (accept && legal && rd != 5'd0) begin
                busy[rd] <= 1'b1;
            end

            if (accept && legal) begin
                ex_valid <= 1'b1;
                ex_in0   <= dec_in0;
                ex_in1   <= dec_in1;
                ex_op    <= dec_op;
                ex_rd    <= rd;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end

            illegal <= accept && !legal;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  logic        clk;
  logic        rst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_in0;
  logic [31:0] ex_in1;
  logic [3:0]  ex_op;
  logic [4:0]  ex_rd;
  logic        illegal;

  decode_stage dut (
    .clk(clk), .rst(rst),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_in0(ex_in0), .ex_in1(ex_in1), .ex_op(ex_op), .ex_rd(ex_rd),
    .illegal(illegal)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [72:0] exp_q[$];          // {op, in0, in1, rd}

  // Reference model: architectural register values, in-flight set,
  // whether the ALU slot holds an item, and whether illegal is due.
  logic [31:0] m_rf [32];
  bit   [31:0] m_busy;
  bit          m_full;
  bit          exp_illegal;
  bit          m_acc;
  logic        last_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) m_rf[k] = 32'd0;
    m_busy = '0;
    m_full = 0;
    exp_illegal = 0;
    m_acc = 0;
    exp_q.delete();
  endtask

  function automatic bit pend(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r] && !(wb_en && wb_rd == r);
  endfunction

  function automatic logic [31:0] rdv(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_en && wb_rd == r) return wb_data;
    return m_rf[r];
  endfunction

  // kind: 0 register-register, 1 register-immediate, 2 single-bit shift, 3 LUI
  task automatic decode(input logic [31:0] i, output bit legal, output logic [3:0] op, output int kind);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = i[31:25];
    f3 = i[14:12];
    legal = 0; op = 4'd0; kind = 0;
    if (i[6:0] == 7'h33) begin
      kind = 0;
      if (f7 == 7'h00 && f3 == 3'd0) begin legal = 1; op = 4'd2; end
      if (f7 == 7'h20 && f3 == 3'd0) begin legal = 1; op = 4'd3; end
      if (f7 == 7'h00 && f3 == 3'd7) begin legal = 1; op = 4'd0; end
      if (f7 == 7'h00 && f3 == 3'd6) begin legal = 1; op = 4'd1; end
    end else if (i[6:0] == 7'h13) begin
      kind = 1;
      if (f3 == 3'd0) begin legal = 1; op = 4'd2; end
      if (f3 == 3'd7) begin legal = 1; op = 4'd0; end
      if (f3 == 3'd6) begin legal = 1; op = 4'd1; end
      if (i[24:20] == 5'd1) begin
        if (f3 == 3'd1 && f7 == 7'h00) begin legal = 1; op = 4'd7; kind = 2; end
        if (f3 == 3'd5 && f7 == 7'h00) begin legal = 1; op = 4'd6; kind = 2; end
        if (f3 == 3'd5 && f7 == 7'h20) begin legal = 1; op = 4'd4; kind = 2; end
      end
    end else if (i[6:0] == 7'h37) begin
      legal = 1; op = 4'd8; kind = 3;
    end
  endtask

  // Called on the falling edge, with this cycle's inputs stable.
  task automatic model_cycle();
    bit legal;
    logic [3:0] op;
    int kind;
    logic [31:0] a, b;
    logic [4:0] s1, s2, d;
    bit haz, exp_rdy;
    check("illegal", 32'(illegal), 32'(exp_illegal));
    check("ex_valid", 32'(ex_valid), 32'(m_full));
    check("busy", dut.busy, m_busy);
    decode(inst, legal, op, kind);
    s1 = inst[19:15];
    s2 = inst[24:20];
    d  = inst[11:7];
    haz = 0;
    if (legal) begin
      if (kind != 3 && pend(s1)) haz = 1;
      if (kind == 0 && pend(s2)) haz = 1;
      if (pend(d)) haz = 1;
    end
    exp_rdy = !haz && (!m_full || ex_ready);
    last_ready = inst_ready;
    check("inst_ready", 32'(inst_ready), 32'(exp_rdy));
    m_acc = inst_valid && exp_rdy;
    case (kind)
      0: begin a = rdv(s1); b = rdv(s2); end
      1: begin a = rdv(s1); b = {{20{inst[31]}}, inst[31:20]}; end
      2: begin a = rdv(s1); b = 32'd0; end
      default: begin a = {12'd0, inst[31:12]}; b = 32'd0; end
    endcase
    if (m_acc && legal) exp_q.push_back({op, a, b, d});
    exp_illegal = m_acc && !legal;
    if (m_acc && legal) m_full = 1;
    else if (ex_ready) m_full = 0;
    if (wb_en && wb_rd != 5'd0) begin
      m_rf[wb_rd] = wb_data;
      m_busy[wb_rd] = 0;
    end
    if (m_acc && legal && d != 5'd0) m_busy[d] = 1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [72:0] e;
    if (!rst && ex_valid && ex_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ex_out unexpected op=%h in0=%h in1=%h rd=%0d", ex_op, ex_in0, ex_in1, ex_rd);
      end else begin
        e = exp_q.pop_front();
        if ({ex_op, ex_in0, ex_in1, ex_rd} !== e) begin
          errors++;
          $display("FAIL ex_out actual op=%h in0=%h in1=%h rd=%0d expected op=%h in0=%h in1=%h rd=%0d",
                   ex_op, ex_in0, ex_in1, ex_rd, e[72:69], e[68:37], e[36:5], e[4:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [31:0] i, input logic we,
                      input logic [4:0] wr, input logic [31:0] wd, input logic er);
    inst_valid = v; inst = i; wb_en = we; wb_rd = wr; wb_data = wd; ex_ready = er;
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; inst_valid = 0; inst = 32'd0; wb_en = 0; wb_rd = 0; wb_data = 0; ex_ready = 0;
    @(negedge clk);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] r2,
                                         input logic [4:0] r1, input logic [2:0] f3, input logic [4:0] d);
    return {f7, r2, r1, f3, d, 7'h33};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] r1,
                                         input logic [2:0] f3, input logic [4:0] d);
    return {imm, r1, f3, d, 7'h13};
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [4:0] d, a, b;
    logic [2:0] f3s [3];
    f3s[0] = 3'd0; f3s[1] = 3'd7; f3s[2] = 3'd6;
    d = 5'($urandom_range(0, 7));
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0, 1: return r_type(7'h00, b, a, f3s[$urandom_range(0, 2)], d);
      2:    return r_type(7'h20, b, a, 3'd0, d);
      3, 4, 5: return i_type(12'($urandom()), a, f3s[$urandom_range(0, 2)], d);
      6: begin
        if ($urandom_range(0, 2) == 0)
          return i_type({7'h00, 5'($urandom_range(0, 3))}, a, 3'd1, d);
        return i_type({($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20, 5'($urandom_range(0, 3))}, a, 3'd5, d);
      end
      7: return {20'($urandom()), d, 7'h37};
      8: return r_type(7'h01, b, a, 3'd0, d);
      default: return $urandom();
    endcase
  endfunction

  task automatic pick_wb(output logic we, output logic [4:0] wr, output logic [31:0] wd);
    int start;
    int r;
    we = 0; wr = 5'd0; wd = $urandom();
    if ($urandom_range(0, 1) == 0) begin
      start = $urandom_range(1, 31);
      for (int k = 0; k < 31; k++) begin
        r = ((start - 1 + k) % 31) + 1;
        if (!we && m_busy[r]) begin we = 1; wr = 5'(r); end
      end
    end else if ($urandom_range(0, 9) == 0) begin
      we = 1; wr = 5'($urandom_range(0, 7));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [72:0] cap;
    logic [31:0] cur;
    logic cur_v;
    logic we;
    logic [4:0] wr;
    logic [31:0] wd;

    rst = 1; inst_valid = 0; inst = 32'd0; wb_en = 0; wb_rd = 0; wb_data = 0; ex_ready = 0;
    model_reset();
    do_reset();

    // Reset state, first cycle after deassertion.
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_ex_in0", ex_in0, 32'd0);
    check("rst_ex_in1", ex_in1, 32'd0);
    check("rst_ex_op", 32'(ex_op), 32'd0);
    check("rst_ex_rd", 32'(ex_rd), 32'd0);
    check("rst_inst_ready", 32'(inst_ready), 32'd1);

    // ADDI x1,x0,5
    step(1, i_type(12'd5, 5'd0, 3'd0, 5'd1), 0, 0, 0, 1);
    check("addi_valid", 32'(ex_valid), 32'd1);
    check("addi_op", 32'(ex_op), 32'h2);
    check("addi_in0", ex_in0, 32'd0);
    check("addi_in1", ex_in1, 32'd5);
    check("addi_rd", 32'(ex_rd), 32'd1);
    check("addi_busy1", 32'(dut.busy[1]), 32'd1);
    step(0, 32'd0, 1, 5'd1, 32'd5, 1);

    // ADDI x1,x0,-1 then ADD x2,x1,x1 stalls until x1 is written back.
    step(1, i_type(12'hFFF, 5'd0, 3'd0, 5'd1), 0, 0, 0, 1);
    step(1, r_type(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 0, 0, 0, 1);
    check("add_stall0", 32'(last_ready), 32'd0);
    step(1, r_type(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 0, 0, 0, 1);
    check("add_stall1", 32'(last_ready), 32'd0);
    step(1, r_type(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 1, 5'd1, 32'hFFFF_FFFF, 1);
    check("add_bypass_accept", 32'(last_ready), 32'd1);
    check("add_in0", ex_in0, 32'hFFFF_FFFF);
    check("add_in1", ex_in1, 32'hFFFF_FFFF);
    check("add_op", 32'(ex_op), 32'h2);

    // LUI x3,0xABCDE
    step(1, {20'hABCDE, 5'd3, 7'h37}, 0, 0, 0, 1);
    check("lui_op", 32'(ex_op), 32'h8);
    check("lui_in0", ex_in0, 32'h000A_BCDE);
    check("lui_in1", ex_in1, 32'd0);
    step(0, 32'd0, 1, 5'd2, 32'h1234, 1);
    step(0, 32'd0, 1, 5'd3, 32'h5678, 1);
    step(0, 32'd0, 1, 5'd5, 32'd100, 1);
    step(0, 32'd0, 1, 5'd6, 32'd30, 1);

    // SUB x4,x5,x6 held by ex_ready=0 for three cycles.
    step(1, r_type(7'h20, 5'd6, 5'd5, 3'd0, 5'd4), 0, 0, 0, 1);
    cap = {ex_op, ex_in0, ex_in1, ex_rd};
    check("sub_in0", ex_in0, 32'd100);
    check("sub_in1", ex_in1, 32'd30);
    for (int k = 0; k < 3; k++) begin
      step(1, i_type(12'd1, 5'd0, 3'd0, 5'd8), 0, 0, 0, 0);
      check("hold_ready", 32'(last_ready), 32'd0);
      check("hold_stable", 32'({ex_op, ex_in0, ex_in1, ex_rd} == cap), 32'd1);
    end
    step(1, i_type(12'd1, 5'd0, 3'd0, 5'd8), 0, 0, 0, 1);
    check("release_accept", 32'(last_ready), 32'd1);

    // Unsupported: SLLI with shamt 2, and MUL.
    step(1, i_type(12'd2, 5'd1, 3'd1, 5'd7), 0, 0, 0, 1);
    check("slli_illegal", 32'(illegal), 32'd1);
    check("slli_no_valid", 32'(ex_valid), 32'd0);
    check("slli_busy7", 32'(dut.busy[7]), 32'd0);
    step(1, r_type(7'h01, 5'd2, 5'd1, 3'd0, 5'd9), 0, 0, 0, 1);
    check("mul_illegal", 32'(illegal), 32'd1);
    check("mul_no_valid", 32'(ex_valid), 32'd0);
    check("mul_busy9", 32'(dut.busy[9]), 32'd0);
    step(0, 32'd0, 0, 0, 0, 1);

    // Reset while an output is pending and x1 is busy.
    step(1, i_type(12'd7, 5'd0, 3'd0, 5'd1), 0, 0, 0, 0);
    check("pre_rst_valid", 32'(ex_valid), 32'd1);
    check("pre_rst_busy1", 32'(dut.busy[1]), 32'd1);
    do_reset();
    check("post_rst_valid", 32'(ex_valid), 32'd0);
    check("post_rst_busy", dut.busy, 32'd0);
    step(1, r_type(7'h00, 5'd0, 5'd1, 3'd0, 5'd10), 0, 0, 0, 1);
    check("post_rst_x1", ex_in0, 32'd0);

    // Randomized traffic.
    cur_v = 0;
    cur = 32'd0;
    for (int c = 0; c < 600; c++) begin
      if (!cur_v) begin
        cur_v = ($urandom_range(0, 3) != 0);
        cur = gen_inst();
      end
      pick_wb(we, wr, wd);
      step(cur_v, cur, we, wr, wd, $urandom_range(0, 3) != 0);
      if (m_acc) cur_v = 0;
    end

    // Drain.
    for (int c = 0; c < 40; c++) begin
      pick_wb(we, wr, wd);
      step(0, 32'd0, we, wr, wd, 1);
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
